// File: rtl/iob_reg_seq_pkg.sv
// Shared definitions for the register-access sequencer: op codes, FSM states
// and the packed command word layout {op, addr, data, mask, strb}.
package iob_reg_seq_pkg;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'd0,
      OP_READ     = 2'd1,
      OP_POLL     = 2'd2,
      OP_WAIT_IRQ = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_IRQW  = 3'd4
   } state_e;

   localparam int OP_W = 2;

   // Field offsets of the command word; strobes occupy the least significant bits.
   function automatic int strb_lsb();
      return 0;
   endfunction

   function automatic int mask_lsb(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int data_lsb(input int data_w);
      return data_w / 8 + data_w;
   endfunction

   function automatic int addr_lsb(input int data_w);
      return data_w / 8 + 2 * data_w;
   endfunction

   function automatic int op_lsb(input int addr_w, input int data_w);
      return addr_lsb(data_w) + addr_w;
   endfunction

   function automatic int cmd_w(input int addr_w, input int data_w);
      return OP_W + addr_w + 2 * data_w + data_w / 8;
   endfunction

endpackage

// File: rtl/iob_seq_fifo.sv
// Synchronous command FIFO with first-word-fall-through output.
// full/empty are derived from registered pointers only.
module iob_seq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         arst_n_i,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/iob_reg_seq.sv
// Register-access sequencer: executes queued WRITE/READ/POLL/WAIT_IRQ commands
// as a valid/ready bus master and returns read/poll results on a response stream.
module iob_reg_seq
   import iob_reg_seq_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int POLL_W = 16
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_data_i,
   input  logic [DATA_W-1:0]   cmd_mask_i,
   input  logic [DATA_W/8-1:0] cmd_strb_i,
   input  logic [POLL_W-1:0]   poll_max_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic                rsp_err_o,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [DATA_W/8-1:0] wstrb_o,
   input  logic                ready_i,
   input  logic [DATA_W-1:0]   rdata_i,
   input  logic                irq_i,
   output logic                busy_o
);

   localparam int STRB_W    = DATA_W / 8;
   localparam int CMD_W     = cmd_w(ADDR_W, DATA_W);
   localparam int STRB_LSB  = strb_lsb();
   localparam int MASK_LSB  = mask_lsb(DATA_W);
   localparam int DATA_LSB  = data_lsb(DATA_W);
   localparam int ADDR_LSB  = addr_lsb(DATA_W);
   localparam int OP_LSB    = op_lsb(ADDR_W, DATA_W);

   function automatic logic [POLL_W-1:0] sat_inc(input logic [POLL_W-1:0] v);
      return (&v) ? v : v + POLL_W'(1);
   endfunction

   function automatic logic [POLL_W-1:0] limit_of(input logic [POLL_W-1:0] m);
      return (m == '0) ? POLL_W'(1) : m;
   endfunction

   logic [CMD_W-1:0]  fifo_din, fifo_dout;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   op_e               fifo_op;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic [POLL_W-1:0] cnt_q, cnt_d;
   logic [POLL_W-1:0] lim_q, lim_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [POLL_W-1:0] cnt_inc;
   logic              poll_hit;

   assign fifo_din  = {cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i, cmd_strb_i};
   assign fifo_push = cmd_valid_i & ~fifo_full;
   assign fifo_op   = op_e'(fifo_dout[OP_LSB +: OP_W]);

   iob_seq_fifo #(
      .W     (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .push     (fifo_push),
      .din      (fifo_din),
      .pop      (fifo_pop),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      strb_d     = strb_q;
      cnt_d      = cnt_q;
      lim_d      = lim_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      fifo_pop   = 1'b0;
      cnt_inc    = sat_inc(cnt_q);
      poll_hit   = ((rdata_i & mask_q) == (data_q & mask_q));

      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_d     = fifo_op;
               addr_d   = fifo_dout[ADDR_LSB +: ADDR_W];
               data_d   = fifo_dout[DATA_LSB +: DATA_W];
               mask_d   = fifo_dout[MASK_LSB +: DATA_W];
               strb_d   = fifo_dout[STRB_LSB +: STRB_W];
               cnt_d    = '0;
               lim_d    = limit_of(poll_max_i);
               state_d  = (fifo_op == OP_WAIT_IRQ) ? ST_IRQW : ST_ISSUE;
            end
         end
         // A zero-wait slave completes in ISSUE; otherwise the same completion runs in WAIT.
         ST_ISSUE, ST_WAIT: begin
            if (ready_i) begin
               case (op_q)
                  OP_READ: begin
                     rsp_data_d = rdata_i;
                     rsp_err_d  = 1'b0;
                     state_d    = ST_RESP;
                  end
                  OP_POLL: begin
                     rsp_data_d = rdata_i;
                     if (poll_hit) begin
                        rsp_err_d = 1'b0;
                        state_d   = ST_RESP;
                     end else if (cnt_inc == lim_q) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                     end else begin
                        cnt_d   = cnt_inc;
                        state_d = ST_ISSUE;
                     end
                  end
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         ST_IRQW: begin
            if (irq_i) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               state_d    = ST_RESP;
            end else if (cnt_inc == lim_q) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_WRITE;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         strb_q     <= '0;
         cnt_q      <= '0;
         lim_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         strb_q     <= strb_d;
         cnt_q      <= cnt_d;
         lim_q      <= lim_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign cmd_ready_o = ~fifo_full;
   assign valid_o     = (state_q == ST_ISSUE);
   assign address_o   = addr_q;
   assign wdata_o     = data_q;
   assign wstrb_o     = (state_q == ST_ISSUE && op_q == OP_WRITE) ? strb_q : '0;
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_reg_seq.sv
// Bench for iob_reg_seq: vector table plus hand-written multi-cycle sequences,
// a modelled bus slave and a response scoreboard.
`timescale 1ns/1ps
module tb_iob_reg_seq;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int POLL_W = 16;

   logic              clk_i = 1'b0;
   logic              arst_n_i;
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [1:0]        cmd_op_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [31:0]       cmd_data_i;
   logic [31:0]       cmd_mask_i;
   logic [3:0]        cmd_strb_i;
   logic [15:0]       poll_max_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_data_o;
   logic              rsp_err_o;
   logic              valid_o;
   logic [ADDR_W-1:0] address_o;
   logic [31:0]       wdata_o;
   logic [3:0]        wstrb_o;
   logic              ready_i;
   logic [31:0]       rdata_i;
   logic              irq_i;
   logic              busy_o;

   iob_reg_seq #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .POLL_W (POLL_W)
   ) dut (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_data_i  (cmd_data_i),
      .cmd_mask_i  (cmd_mask_i),
      .cmd_strb_i  (cmd_strb_i),
      .poll_max_i  (poll_max_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .valid_o     (valid_o),
      .address_o   (address_o),
      .wdata_o     (wdata_o),
      .wstrb_o     (wstrb_o),
      .ready_i     (ready_i),
      .rdata_i     (rdata_i),
      .irq_i       (irq_i),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- bus slave model ----------------
   int          slv_lat;
   logic        slv_hold;
   logic [31:0] slv_dflt;
   logic [31:0] rd_arr [64];
   int          rd_n;
   int          rd_idx = 0;
   logic        pend;
   logic        pend_rd;
   int          wcnt;
   int          n_txn = 0;
   int          cyc = 0;
   logic [ADDR_W-1:0] log_addr  [128];
   logic [31:0]       log_wdata [128];
   logic [3:0]        log_strb  [128];
   int                log_cyc   [128];

   assign ready_i = !slv_hold && ((slv_lat == 0 && valid_o) || (pend && wcnt == 0));
   assign rdata_i = (rd_idx < rd_n) ? rd_arr[rd_idx] : slv_dflt;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         pend    <= 1'b0;
         pend_rd <= 1'b0;
         wcnt    <= 0;
      end else begin
         if (valid_o) begin
            if (n_txn < 128) begin
               log_addr[n_txn]  <= address_o;
               log_wdata[n_txn] <= wdata_o;
               log_strb[n_txn]  <= wstrb_o;
               log_cyc[n_txn]   <= cyc;
            end
            n_txn <= n_txn + 1;
            if (ready_i) begin
               if (wstrb_o == 4'h0 && rd_idx < rd_n) rd_idx <= rd_idx + 1;
            end else begin
               pend    <= 1'b1;
               pend_rd <= (wstrb_o == 4'h0);
               wcnt    <= (slv_lat > 0) ? slv_lat - 1 : 0;
            end
         end else if (pend) begin
            if (ready_i) begin
               pend <= 1'b0;
               if (pend_rd && rd_idx < rd_n) rd_idx <= rd_idx + 1;
            end else if (wcnt > 0) begin
               wcnt <= wcnt - 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } rsp_t;
   rsp_t sb_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic exp_rsp(input logic [31:0] d, input logic e);
      rsp_t r;
      r.data = d;
      r.err  = e;
      sb_q.push_back(r);
   endtask

   task automatic load_reads(input int n, input logic [31:0] r0, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] dflt);
      rd_arr[rd_idx]     = r0;
      rd_arr[rd_idx + 1] = r1;
      rd_arr[rd_idx + 2] = r2;
      rd_n     = rd_idx + n;
      slv_dflt = dflt;
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input logic [3:0] strb);
      int n;
      n = 0;
      @(negedge clk_i);
      cmd_op_i    = op;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      cmd_mask_i  = mask;
      cmd_strb_i  = strb;
      cmd_valid_i = 1'b1;
      while (!cmd_ready_o && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      if (!cmd_ready_o) fail_now("push_ready");
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic get_rsp(input string name);
      rsp_t e;
      int   n;
      n = 0;
      rsp_ready_i = 1'b1;
      while (!rsp_valid_o && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      if (!rsp_valid_o) begin
         fail_now({name, "_rsp"});
         rsp_ready_i = 1'b0;
         return;
      end
      if (sb_q.size() == 0) begin
         fail_now({name, "_unexpected_rsp"});
      end else begin
         e = sb_q.pop_front();
         chk({name, "_data"}, rsp_data_o, e.data);
         chk({name, "_err"}, rsp_err_o, e.err);
      end
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_o && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o) fail_now({name, "_idle"});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [31:0]       mask;
      logic [3:0]        strb;
      logic [15:0]       pmax;
      int                lat;
      int                nrd;
      logic [31:0]       rd0;
      logic [31:0]       rd1;
      logic [31:0]       rd2;
      logic [31:0]       dflt;
      logic              has_rsp;
      logic [31:0]       exp_data;
      logic              exp_err;
      int                exp_txn;
      logic [3:0]        exp_strb;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int n;

      vecs[0] = '{2'd0, 12'h000, 32'h0000A080, 32'h0, 4'hF, 16'd1,  0, 0, 32'h0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0, 1, 4'hF};
      vecs[1] = '{2'd1, 12'h004, 32'h0, 32'h0, 4'h0, 16'd1,  1, 1, 32'h80, 32'h0, 32'h0, 32'h0,      1'b1, 32'h80, 1'b0, 1, 4'h0};
      vecs[2] = '{2'd1, 12'h008, 32'h0, 32'h0, 4'h0, 16'd1,  0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1, 4'h0};
      vecs[3] = '{2'd2, 12'h010, 32'h4, 32'h4, 4'h0, 16'd10, 1, 3, 32'h1, 32'h1, 32'h5, 32'h0,       1'b1, 32'h5, 1'b0, 3, 4'h0};
      vecs[4] = '{2'd2, 12'h014, 32'hAA, 32'hFF, 4'h0, 16'd4, 0, 0, 32'h0, 32'h0, 32'h0, 32'h11,     1'b1, 32'h11, 1'b1, 4, 4'h0};
      vecs[5] = '{2'd2, 12'h018, 32'h1, 32'h1, 4'h0, 16'd0,  2, 0, 32'h0, 32'h0, 32'h0, 32'h0,       1'b1, 32'h0, 1'b1, 1, 4'h0};
      vecs[6] = '{2'd2, 12'h01C, 32'h1, 32'h1, 4'h0, 16'd0,  0, 1, 32'h3, 32'h0, 32'h0, 32'h0,       1'b1, 32'h3, 1'b0, 1, 4'h0};
      vecs[7] = '{2'd0, 12'h020, 32'h12345678, 32'h0, 4'h3, 16'd1, 2, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1, 4'h3};
      vecs[8] = '{2'd3, 12'h000, 32'h0, 32'h0, 4'h0, 16'd5,  0, 0, 32'h0, 32'h0, 32'h0, 32'h0,       1'b1, 32'h0, 1'b1, 0, 4'h0};

      arst_n_i    = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'd0;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      cmd_mask_i  = '0;
      cmd_strb_i  = '0;
      poll_max_i  = 16'd1;
      rsp_ready_i = 1'b0;
      irq_i       = 1'b0;
      slv_lat     = 0;
      slv_hold    = 1'b0;
      slv_dflt    = 32'h0;
      rd_n        = 0;

      repeat (3) @(negedge clk_i);
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_bus_out", {address_o, wdata_o, wstrb_o}, 0);
      chk("rst_rsp_out", {rsp_data_o, rsp_err_o}, 0);
      arst_n_i = 1'b1;
      @(negedge clk_i);

      // Table-driven single commands.
      for (int i = 0; i < 9; i++) begin
         slv_lat = vecs[i].lat;
         load_reads(vecs[i].nrd, vecs[i].rd0, vecs[i].rd1, vecs[i].rd2, vecs[i].dflt);
         poll_max_i = vecs[i].pmax;
         base = n_txn;
         if (vecs[i].has_rsp) exp_rsp(vecs[i].exp_data, vecs[i].exp_err);
         push_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].strb);
         if (vecs[i].has_rsp) get_rsp($sformatf("v%0d", i));
         wait_idle($sformatf("v%0d", i));
         chk($sformatf("v%0d_txns", i), n_txn - base, vecs[i].exp_txn);
         if (vecs[i].exp_txn > 0) begin
            chk($sformatf("v%0d_addr", i), log_addr[base], vecs[i].addr);
            chk($sformatf("v%0d_strb", i), log_strb[base], vecs[i].exp_strb);
            if (vecs[i].op == 2'd0) chk($sformatf("v%0d_wdata", i), log_wdata[base], vecs[i].data);
         end
      end

      // WRITE timing with a zero-wait slave, then back-to-back WRITEs.
      slv_lat = 0;
      poll_max_i = 16'd1;
      push_cmd(2'd0, 12'h100, 32'hCAFE, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("wr_early_valid", valid_o, 0);
      @(negedge clk_i);
      chk("wr_pulse", {valid_o, address_o, wdata_o, wstrb_o}, {1'b1, 12'h100, 32'hCAFE, 4'hF});
      @(negedge clk_i);
      chk("wr_pulse_end", valid_o, 0);
      @(negedge clk_i);
      chk("wr_busy_drop", busy_o, 0);
      base = n_txn;
      push_cmd(2'd0, 12'h104, 32'h1, 32'h0, 4'hF);
      push_cmd(2'd0, 12'h108, 32'h2, 32'h0, 4'hF);
      wait_idle("b2b");
      chk("b2b_txns", n_txn - base, 2);
      chk("b2b_order", {log_addr[base], log_addr[base + 1]}, {12'h104, 12'h108});
      chk("b2b_spacing", log_cyc[base + 1] - log_cyc[base], 2);

      // READ with 3-cycle slave, response stalled 4 cycles with a WRITE queued behind it.
      slv_lat = 3;
      load_reads(1, 32'h80, 32'h0, 32'h0, 32'h0);
      base = n_txn;
      exp_rsp(32'h80, 1'b0);
      push_cmd(2'd1, 12'h004, 32'h0, 32'h0, 4'h0);
      push_cmd(2'd0, 12'h0F0, 32'h55, 32'h0, 4'hF);
      n = 0;
      while (!rsp_valid_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("stall_rsp_valid", rsp_valid_o, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk($sformatf("stall_hold%0d", k), {rsp_valid_o, rsp_data_o, rsp_err_o, valid_o},
             {1'b1, 32'h80, 1'b0, 1'b0});
      end
      get_rsp("stall");
      wait_idle("stall");
      chk("stall_txns", n_txn - base, 2);
      chk("stall_queued_wr", log_addr[base + 1], 12'h0F0);

      // Poll retries follow each mismatch without an idle cycle.
      slv_lat = 0;
      load_reads(0, 32'h0, 32'h0, 32'h0, 32'h0);
      poll_max_i = 16'd3;
      base = n_txn;
      exp_rsp(32'h0, 1'b1);
      push_cmd(2'd2, 12'h030, 32'h1, 32'h1, 4'h0);
      get_rsp("retry");
      wait_idle("retry");
      chk("retry_txns", n_txn - base, 3);
      chk("retry_gap1", log_cyc[base + 1] - log_cyc[base], 1);
      chk("retry_gap2", log_cyc[base + 2] - log_cyc[base + 1], 1);

      // WAIT_IRQ: interrupt arrives, then timeout with no interrupt.
      poll_max_i = 16'd50;
      exp_rsp(32'h0, 1'b0);
      push_cmd(2'd3, 12'h000, 32'h0, 32'h0, 4'h0);
      n = 0;
      while (!rsp_valid_o && n < 200) begin
         @(negedge clk_i);
         n++;
         if (n == 20) irq_i = 1'b1;
      end
      chk("irq_latency", n, 21);
      get_rsp("irq");
      irq_i = 1'b0;
      wait_idle("irq");
      exp_rsp(32'h0, 1'b1);
      push_cmd(2'd3, 12'h000, 32'h0, 32'h0, 4'h0);
      n = 0;
      while (!rsp_valid_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("irq_timeout_cycles", n, 52);
      get_rsp("irq_to");
      wait_idle("irq_to");

      // Fill the FIFO behind a stalled slave, then drain in order.
      slv_hold = 1'b1;
      slv_lat = 0;
      poll_max_i = 16'd1;
      base = n_txn;
      for (int k = 0; k < 9; k++) push_cmd(2'd0, 12'(12'h200 + 4 * k), 32'(k), 32'h0, 4'hF);
      @(negedge clk_i);
      chk("full_cmd_ready", cmd_ready_o, 0);
      chk("full_busy", busy_o, 1);
      slv_hold = 1'b0;
      wait_idle("drain");
      chk("drain_txns", n_txn - base, 9);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("drain_addr%0d", k), log_addr[base + k], 12'(12'h200 + 4 * k));
         chk($sformatf("drain_wdata%0d", k), log_wdata[base + k], 32'(k));
      end

      // Reset while a READ waits on the bus with a WRITE still queued.
      slv_hold = 1'b1;
      push_cmd(2'd1, 12'h300, 32'h0, 32'h0, 4'h0);
      push_cmd(2'd0, 12'h304, 32'h9, 32'h0, 4'hF);
      repeat (3) @(negedge clk_i);
      chk("mid_busy", busy_o, 1);
      base = n_txn;
      arst_n_i = 1'b0;
      #1;
      chk("arst_outputs", {cmd_ready_o, valid_o, rsp_valid_o, busy_o, address_o, wstrb_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0});
      @(negedge clk_i);
      arst_n_i = 1'b1;
      slv_hold = 1'b0;
      repeat (10) @(negedge clk_i);
      chk("arst_flushed_txns", n_txn - base, 0);
      chk("arst_idle", {busy_o, rsp_valid_o}, 0);

      chk("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
